// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types, BCD limits and field slices for the alarm clock
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2
  } state_t;

  localparam logic [3:0] MAX_MS_HOUR       = 4'd2;
  localparam logic [3:0] MAX_LS_HOUR_AT_20 = 4'd3;
  localparam logic [3:0] MAX_MS_MIN        = 4'd5;
  localparam logic [3:0] MAX_DIGIT         = 4'd9;

  localparam logic [15:0] MIDNIGHT = 16'h0000;

  // Packing of the 16-bit time word: {ms_hour, ls_hour, ms_min, ls_min}
  localparam int MS_HOUR_MSB = 15;
  localparam int MS_HOUR_LSB = 12;
  localparam int LS_HOUR_MSB = 11;
  localparam int LS_HOUR_LSB = 8;
  localparam int MS_MIN_MSB  = 7;
  localparam int MS_MIN_LSB  = 4;
  localparam int LS_MIN_MSB  = 3;
  localparam int LS_MIN_LSB  = 0;

  // Range check of a completed entry; individual digits are already known to be <= 9
  function automatic logic bcd_time_valid(input logic [15:0] t);
    logic [3:0] ms_hour;
    logic [3:0] ls_hour;
    logic [3:0] ms_min;
    ms_hour = t[MS_HOUR_MSB:MS_HOUR_LSB];
    ls_hour = t[LS_HOUR_MSB:LS_HOUR_LSB];
    ms_min  = t[MS_MIN_MSB:MS_MIN_LSB];
    return (ms_hour <= MAX_MS_HOUR) &&
           ((ms_hour != MAX_MS_HOUR) || (ls_hour <= MAX_LS_HOUR_AT_20)) &&
           (ms_min <= MAX_MS_MIN);
  endfunction

endpackage

// File: rtl/alarm_clock_ctrl_if.sv
// rtl/alarm_clock_ctrl_if.sv - keypad/button inputs and display outputs of the alarm clock
interface alarm_clock_ctrl_if;
  logic        key_valid;
  logic [3:0]  key_digit;
  logic        time_button;
  logic        alarm_button;
  logic [15:0] current_time;
  logic [15:0] alarm_time;
  logic        one_minute;
  logic        show_alarm;
  logic        load_error;

  modport master (
    output key_valid, key_digit, time_button, alarm_button,
    input  current_time, alarm_time, one_minute, show_alarm, load_error
  );

  modport slave (
    input  key_valid, key_digit, time_button, alarm_button,
    output current_time, alarm_time, one_minute, show_alarm, load_error
  );
endinterface

// File: rtl/bcd_time_incr.sv
// rtl/bcd_time_incr.sv - adds one minute to a BCD HH:MM word, wrapping 23:59 to 00:00
module bcd_time_incr
  import alarm_pkg::*;
(
  input  logic [15:0] time_in,
  output logic [15:0] time_out
);

  logic [3:0] ms_hour;
  logic [3:0] ls_hour;
  logic [3:0] ms_min;
  logic [3:0] ls_min;

  assign ms_hour = time_in[MS_HOUR_MSB:MS_HOUR_LSB];
  assign ls_hour = time_in[LS_HOUR_MSB:LS_HOUR_LSB];
  assign ms_min  = time_in[MS_MIN_MSB:MS_MIN_LSB];
  assign ls_min  = time_in[LS_MIN_MSB:LS_MIN_LSB];

  // Ripple the carry from ls_min upward; hours wrap as a pair at 23
  always_comb begin
    time_out = time_in;
    if (ls_min != MAX_DIGIT) begin
      time_out[LS_MIN_MSB:LS_MIN_LSB] = ls_min + 4'd1;
    end else begin
      time_out[LS_MIN_MSB:LS_MIN_LSB] = 4'd0;
      if (ms_min != MAX_MS_MIN) begin
        time_out[MS_MIN_MSB:MS_MIN_LSB] = ms_min + 4'd1;
      end else begin
        time_out[MS_MIN_MSB:MS_MIN_LSB] = 4'd0;
        if ((ms_hour == MAX_MS_HOUR) && (ls_hour == MAX_LS_HOUR_AT_20)) begin
          time_out[MS_HOUR_MSB:LS_HOUR_LSB] = 8'h00;
        end else if (ls_hour == MAX_DIGIT) begin
          time_out[LS_HOUR_MSB:LS_HOUR_LSB] = 4'd0;
          time_out[MS_HOUR_MSB:MS_HOUR_LSB] = ms_hour + 4'd1;
        end else begin
          time_out[LS_HOUR_MSB:LS_HOUR_LSB] = ls_hour + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/alarm_clock_ctrl.sv
// rtl/alarm_clock_ctrl.sv - minute prescaler, time/alarm registers and keypad entry sequencer
module alarm_clock_ctrl
  import alarm_pkg::*;
#(
  parameter int TICKS_PER_MINUTE = 60
) (
  input  logic             clk,
  input  logic             reset,
  alarm_clock_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(TICKS_PER_MINUTE);

  state_t           state;
  logic [CNT_W-1:0] prescaler;
  logic [15:0]      current_time_q;
  logic [15:0]      alarm_time_q;
  logic [15:0]      entry_buf;
  logic [1:0]       digit_cnt;
  logic             one_minute_q;
  logic             show_alarm_q;
  logic             load_error_q;

  logic [15:0]      time_plus;
  logic [15:0]      entry_next;
  logic             tick;
  logic             digit_ok;
  logic             entry_ok;
  logic             any_button;

  bcd_time_incr u_incr (
    .time_in  (current_time_q),
    .time_out (time_plus)
  );

  // Prescaler is frozen while the time is being entered
  assign tick       = (state != SET_TIME) && (prescaler == CNT_W'(TICKS_PER_MINUTE - 1));
  assign entry_next = {entry_buf[11:0], bus.key_digit};
  assign digit_ok   = (bus.key_digit <= MAX_DIGIT);
  assign entry_ok   = bcd_time_valid(entry_next);
  assign any_button = bus.time_button | bus.alarm_button;

  assign bus.current_time = current_time_q;
  assign bus.alarm_time   = alarm_time_q;
  assign bus.one_minute   = one_minute_q;
  assign bus.show_alarm   = show_alarm_q;
  assign bus.load_error   = load_error_q;

  // Timekeeping plus the entry FSM; strobes default low so they never stretch
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      prescaler      <= '0;
      current_time_q <= MIDNIGHT;
      alarm_time_q   <= MIDNIGHT;
      entry_buf      <= '0;
      digit_cnt      <= '0;
      one_minute_q   <= 1'b0;
      show_alarm_q   <= 1'b0;
      load_error_q   <= 1'b0;
    end else begin
      one_minute_q <= 1'b0;
      load_error_q <= 1'b0;

      if (state != SET_TIME) begin
        if (tick) begin
          prescaler      <= '0;
          one_minute_q   <= 1'b1;
          current_time_q <= time_plus;
        end else begin
          prescaler <= prescaler + CNT_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (bus.time_button) begin
            state        <= SET_TIME;
            show_alarm_q <= 1'b0;
            digit_cnt    <= '0;
            entry_buf    <= '0;
          end else if (bus.alarm_button) begin
            state        <= SET_ALARM;
            show_alarm_q <= 1'b1;
            digit_cnt    <= '0;
            entry_buf    <= '0;
          end
        end
        SET_TIME, SET_ALARM: begin
          if (any_button) begin
            state        <= IDLE;
            show_alarm_q <= 1'b0;
          end else if (bus.key_valid) begin
            if (!digit_ok) begin
              load_error_q <= 1'b1;
            end else if (digit_cnt == 2'd3) begin
              state        <= IDLE;
              show_alarm_q <= 1'b0;
              if (!entry_ok) begin
                load_error_q <= 1'b1;
              end else if (state == SET_TIME) begin
                current_time_q <= entry_next;
                prescaler      <= '0;
              end else begin
                alarm_time_q <= entry_next;
              end
            end else begin
              entry_buf <= entry_next;
              digit_cnt <= digit_cnt + 2'd1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          show_alarm_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// tb/tb_alarm_clock_ctrl.sv - directed vector bench for alarm_clock_ctrl with four ticks per minute
module tb_alarm_clock_ctrl;

  logic clk = 1'b0;
  logic reset;

  alarm_clock_ctrl_if bus();

  alarm_clock_ctrl #(.TICKS_PER_MINUTE(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        kv;
    logic [3:0]  kd;
    logic        tbtn;
    logic        abtn;
    logic [15:0] ct;
    logic [15:0] at;
    logic        om;
    logic        sa;
    logic        le;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic rst, input logic kv, input logic [3:0] kd,
                              input logic tbtn, input logic abtn,
                              input logic [15:0] ct, input logic [15:0] at,
                              input logic om, input logic sa, input logic le);
    vec_t v;
    v.rst = rst; v.kv = kv; v.kd = kd; v.tbtn = tbtn; v.abtn = abtn;
    v.ct = ct; v.at = at; v.om = om; v.sa = sa; v.le = le;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic kv, input logic [3:0] kd,
                       input logic tbtn, input logic abtn);
    reset            = rst;
    bus.key_valid    = kv;
    bus.key_digit    = kd;
    bus.time_button  = tbtn;
    bus.alarm_button = abtn;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_and_run(input logic [15:0] value, input logic [15:0] next_value);
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    step();
    check("load_btn_om", {15'd0, bus.one_minute}, 16'd0);
    for (int i = 3; i >= 0; i--) begin
      drive(1'b0, 1'b1, value[i*4 +: 4], 1'b0, 1'b0);
      step();
    end
    check("load_ct", bus.current_time, value);
    check("load_om", {15'd0, bus.one_minute}, 16'd0);
    check("load_le", {15'd0, bus.load_error}, 16'd0);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("run_om_low", {15'd0, bus.one_minute}, 16'd0);
      check("run_ct_hold", bus.current_time, value);
    end
    step();
    check("run_om_high", {15'd0, bus.one_minute}, 16'd1);
    check("run_ct_next", bus.current_time, next_value);
  endtask

  initial begin
    drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);

    // reset, then first minute after four ticks
    vecs.push_back(mk(1, 0, 4'd0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'd0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'd0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'd0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'd0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'd0, 0, 0, 16'h0001, 16'h0000, 1, 0, 0));
    vecs.push_back(mk(0, 0, 4'd0, 0, 0, 16'h0001, 16'h0000, 0, 0, 0));
    // set time 23:59, frozen during entry, wraps to 00:00 four cycles after load
    vecs.push_back(mk(0, 0, 4'd0, 1, 0, 16'h0001, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd2, 0, 0, 16'h0001, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd3, 0, 0, 16'h0001, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd5, 0, 0, 16'h0001, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd9, 0, 0, 16'h2359, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'd0, 0, 0, 16'h2359, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'd0, 0, 0, 16'h2359, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'd0, 0, 0, 16'h2359, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'd0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0));
    // set alarm 07:30 while time keeps running
    vecs.push_back(mk(0, 0, 4'd0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 4'd0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 4'd7, 0, 0, 16'h0000, 16'h0000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 4'd3, 0, 0, 16'h0001, 16'h0000, 1, 1, 0));
    vecs.push_back(mk(0, 1, 4'd0, 0, 0, 16'h0001, 16'h0730, 0, 0, 0));
    // invalid 24:00 rejected, clock resumes from held prescaler
    vecs.push_back(mk(0, 0, 4'd0, 1, 0, 16'h0001, 16'h0730, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd2, 0, 0, 16'h0001, 16'h0730, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd4, 0, 0, 16'h0001, 16'h0730, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd0, 0, 0, 16'h0001, 16'h0730, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd0, 0, 0, 16'h0001, 16'h0730, 0, 0, 1));
    vecs.push_back(mk(0, 0, 4'd0, 0, 0, 16'h0001, 16'h0730, 0, 0, 0));
    vecs.push_back(mk(0, 0, 4'd0, 0, 0, 16'h0002, 16'h0730, 1, 0, 0));
    // non-BCD digit dropped mid-entry without advancing the count
    vecs.push_back(mk(0, 0, 4'd0, 1, 0, 16'h0002, 16'h0730, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd1, 0, 0, 16'h0002, 16'h0730, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'hA, 0, 0, 16'h0002, 16'h0730, 0, 0, 1));
    vecs.push_back(mk(0, 1, 4'd2, 0, 0, 16'h0002, 16'h0730, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd3, 0, 0, 16'h0002, 16'h0730, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd4, 0, 0, 16'h1234, 16'h0730, 0, 0, 0));
    // alarm entry aborted by time_button
    vecs.push_back(mk(0, 0, 4'd0, 0, 1, 16'h1234, 16'h0730, 0, 1, 0));
    vecs.push_back(mk(0, 1, 4'd1, 0, 0, 16'h1234, 16'h0730, 0, 1, 0));
    vecs.push_back(mk(0, 1, 4'd2, 0, 0, 16'h1234, 16'h0730, 0, 1, 0));
    vecs.push_back(mk(0, 0, 4'd0, 1, 0, 16'h1235, 16'h0730, 1, 0, 0));
    vecs.push_back(mk(0, 0, 4'd0, 0, 0, 16'h1235, 16'h0730, 0, 0, 0));
    // alarm entry killed by reset; later keys in IDLE load nothing
    vecs.push_back(mk(0, 0, 4'd0, 0, 1, 16'h1235, 16'h0730, 0, 1, 0));
    vecs.push_back(mk(0, 1, 4'd1, 0, 0, 16'h1235, 16'h0730, 0, 1, 0));
    vecs.push_back(mk(0, 1, 4'd2, 0, 0, 16'h1236, 16'h0730, 1, 1, 0));
    vecs.push_back(mk(1, 0, 4'd0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd3, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd4, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd5, 0, 0, 16'h0000, 16'h0000, 0, 0, 0));
    vecs.push_back(mk(0, 1, 4'd6, 0, 0, 16'h0001, 16'h0000, 1, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].kv, vecs[i].kd, vecs[i].tbtn, vecs[i].abtn);
      step();
      check($sformatf("v%0d_current_time", i), bus.current_time, vecs[i].ct);
      check($sformatf("v%0d_alarm_time", i), bus.alarm_time, vecs[i].at);
      check($sformatf("v%0d_one_minute", i), {15'd0, bus.one_minute}, {15'd0, vecs[i].om});
      check($sformatf("v%0d_show_alarm", i), {15'd0, bus.show_alarm}, {15'd0, vecs[i].sa});
      check($sformatf("v%0d_load_error", i), {15'd0, bus.load_error}, {15'd0, vecs[i].le});
    end

    // hour carries out of ls_hour
    load_and_run(16'h0959, 16'h1000);
    load_and_run(16'h1959, 16'h2000);

    // both buttons in IDLE: time entry wins, prescaler freezes
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    step();
    check("both_btn_show_alarm", {15'd0, bus.show_alarm}, 16'd0);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step();
      check("both_btn_frozen_om", {15'd0, bus.one_minute}, 16'd0);
      check("both_btn_frozen_ct", bus.current_time, 16'h2000);
      check("both_btn_show_low", {15'd0, bus.show_alarm}, 16'd0);
    end
    drive(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    step();
    check("abort_le", {15'd0, bus.load_error}, 16'd0);
    check("abort_ct", bus.current_time, 16'h2000);
    check("abort_at", bus.alarm_time, 16'h0000);
    drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alarm_clock_ctrl.md
Name: alarm_clock_ctrl

Overview:
Timekeeping and user-entry sequencer for the alarm clock.
- Divides the system clock into a one-cycle one_minute strobe.
- Holds the BCD time-of-day (HH:MM) and the alarm time.
- Runs a keypad entry state machine that sets either register.
- Drives current_time, alarm_time, one_minute and show_alarm directly into the display/alarm driver.

Parameters:
TICKS_PER_MINUTE, 60, clk cycles per minute (60 for a 1 Hz clk); must be >= 2.
CNT_W, $clog2(TICKS_PER_MINUTE), prescaler width; derived, not overridden.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
key_valid  in  1  one-cycle strobe; key_digit is valid when this is high.
key_digit  in  4  BCD digit from keypad.
time_button  in  1  one-cycle strobe: start or abort time entry.
alarm_button  in  1  one-cycle strobe: start or abort alarm entry.
current_time  out  16  BCD {ms_hour, ls_hour, ms_min, ls_min}.
alarm_time  out  16  BCD alarm time, same packing.
one_minute  out  1  one-cycle strobe at each minute boundary.
show_alarm  out  1  high while alarm entry is in progress.
load_error  out  1  one-cycle strobe on a rejected digit or entry.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - current_time = 16'h0000, alarm_time = 16'h0000.
  - one_minute = 0, show_alarm = 0, load_error = 0.
  - prescaler = 0, state = IDLE, digit count = 0, entry buffer = 0.
- Reset mid-entry: discards the partial entry, loads nothing.
- Prescaler:
  - Counts 0 .. TICKS_PER_MINUTE-1 while state != SET_TIME.
  - On the terminal count it wraps to 0. On that same edge one_minute is registered high for exactly one cycle and current_time takes the incremented value. The strobe and the new time are therefore visible in the same cycle.
- BCD increment rules:
  - ls_min 9 -> 0 with carry.
  - ms_min 5 -> 0 with carry.
  - ls_hour 9 -> 0 with carry into ms_hour.
  - 23:59 -> 00:00.
  - Other digits increment by 1.
- States: IDLE, SET_TIME, SET_ALARM.
- IDLE:
  - time_button -> SET_TIME; alarm_button -> SET_ALARM.
  - Both buttons in the same cycle -> SET_TIME (time_button wins).
  - key_valid is ignored.
  - Entering either SET state clears the digit count and entry buffer.
- SET_TIME / SET_ALARM:
  - Each key_valid with key_digit <= 9 shifts the digit in, most-significant first: buf = {buf[11:0], key_digit}; count increments.
  - key_digit > 9: load_error pulses, the digit is dropped, count is unchanged.
  - Either button during entry aborts to IDLE with no load. There is no error and the abort takes priority over a key_valid in the same cycle.
- Completion: on the cycle the 4th digit is accepted, the completed value is validated combinationally. Rules:
  - ms_hour <= 2.
  - If ms_hour == 2 then ls_hour <= 3.
  - ms_min <= 5.
- Valid completion, on the next edge:
  - SET_TIME: current_time loads the value and the prescaler clears to 0.
  - SET_ALARM: alarm_time loads the value.
  - State -> IDLE.
- Invalid completion: load_error pulses one cycle, nothing loads, state -> IDLE.
- SET_TIME freeze:
  - Prescaler is held and one_minute is suppressed.
  - The first one_minute after a time load arrives exactly TICKS_PER_MINUTE cycles after the load edge.
- SET_ALARM: timekeeping continues, so one_minute and current_time keep updating during alarm entry.
- show_alarm = (state == SET_ALARM), registered.
- load_error and one_minute never stretch beyond one cycle.

Decomposition:
- Shared package alarm_pkg holds:
  - the state enum (IDLE, SET_TIME, SET_ALARM);
  - BCD digit limits (MAX_MS_HOUR=2, MAX_LS_HOUR_AT_20=3, MAX_MS_MIN=5, MAX_DIGIT=9);
  - MIDNIGHT = 16'h0000;
  - field slice constants for the 16-bit packing.
- One combinational sub-module, bcd_time_incr: 16-bit BCD in, 16-bit BCD incremented by one minute out, with the 23:59 -> 00:00 wrap.
  - Reused later by the snooze path.

Test Plan (TICKS_PER_MINUTE=4):
1. Reset, then run 4 cycles -> all outputs 0 during reset; after the 4th post-reset edge one_minute=1 for one cycle and current_time=16'h0001.
2. time_button; keys 2,3,5,9 -> current_time=16'h2359, no one_minute during entry; exactly 4 cycles after the load edge one_minute=1 and current_time=16'h0000.
3. alarm_button; keys 0,7,3,0 -> show_alarm=1 from the cycle after the button until the load edge; alarm_time=16'h0730; current_time keeps advancing meanwhile.
4. time_button; keys 2,4,0,0 -> load_error one cycle after the 4th key, current_time unchanged, state IDLE. Separately, key 4'hA mid-entry -> load_error, digit count unchanged.
5. alarm_button; keys 1,2; then time_button -> IDLE, alarm_time unchanged, no load_error. Repeat with reset asserted after 2 digits -> IDLE, nothing loaded.
6. Load 16'h0959 -> after 4 cycles current_time=16'h1000. Load 16'h1959 -> 16'h2000. Both buttons in the same cycle in IDLE -> SET_TIME, show_alarm stays 0.
